chess_clock: RTL and testbench

- Game-state timer that produces the `white_win` / `black_win` flags consumed by the win-screen overlay stage.
- Keeps a countdown clock per player, toggles the turn on each completed move and adds a per-move increment.
- Declares the winner on timeout or king capture.
- Remaining times and turn are exported for on-screen clock/turn drawing stages.

---
 rtl/chess_clock_if.sv | 26 ++
 rtl/chess_clock.sv | 125 ++++++++++++
 tb/tb_chess_clock.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/chess_clock_if.sv
// Bundle of game-control inputs and clock/result outputs for the chess clock.
// The master modport drives the moves and starts; the slave modport is the timer itself.
interface chess_clock_if #(
  parameter int TIME_W = 12
);
  logic              start;
  logic              move_done;
  logic              white_king_lost;
  logic              black_king_lost;
  logic              white_win;
  logic              black_win;
  logic [TIME_W-1:0] white_time;
  logic [TIME_W-1:0] black_time;
  logic              turn;
  logic              running;

  modport master (
    output start, move_done, white_king_lost, black_king_lost,
    input  white_win, black_win, white_time, black_time, turn, running
  );

  modport slave (
    input  start, move_done, white_king_lost, black_king_lost,
    output white_win, black_win, white_time, black_time, turn, running
  );
endinterface

// File: rtl/chess_clock.sv
// Two-player countdown chess clock with per-move increment; flags the winner on
// timeout or king capture. Every output comes straight from a flop.
module chess_clock #(
  parameter int CYCLES_PER_SEC = 65_000_000,
  parameter int TIME_SEC       = 300,
  parameter int INC_SEC        = 2,
  parameter int TIME_W         = 12
) (
  input  logic         clk,
  input  logic         rst,
  chess_clock_if.slave bus
);
  localparam int          PRE_W  = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
  localparam int unsigned MAX_T  = (2 ** TIME_W) - 1;
  localparam logic [TIME_W-1:0] START_T = TIME_W'(TIME_SEC);
  localparam logic [PRE_W-1:0]  PRE_TOP = PRE_W'(CYCLES_PER_SEC - 1);

  typedef enum logic [1:0] {IDLE, RUN_W, RUN_B, OVER} state_t;

  state_t            state_q, state_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [TIME_W-1:0] white_time_q, white_time_d;
  logic [TIME_W-1:0] black_time_q, black_time_d;
  logic              white_win_q, white_win_d;
  logic              black_win_q, black_win_d;
  logic              turn_q, turn_d;
  logic              running_q, running_d;

  logic              in_run;
  logic              tick;
  logic [TIME_W-1:0] active, active_d, inc_val;
  logic [31:0]       bump;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pre_q        <= '0;
      white_time_q <= START_T;
      black_time_q <= START_T;
      white_win_q  <= 1'b0;
      black_win_q  <= 1'b0;
      turn_q       <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      white_time_q <= white_time_d;
      black_time_q <= black_time_d;
      white_win_q  <= white_win_d;
      black_win_q  <= black_win_d;
      turn_q       <= turn_d;
      running_q    <= running_d;
    end
  end

  // Only the side to move has a live clock; "active" is that side's time.
  always_comb begin
    state_d      = state_q;
    pre_d        = pre_q;
    white_time_d = white_time_q;
    black_time_d = black_time_q;
    white_win_d  = white_win_q;
    black_win_d  = black_win_q;
    turn_d       = turn_q;
    running_d    = running_q;

    in_run   = (state_q == RUN_W) || (state_q == RUN_B);
    tick     = in_run && (pre_q == PRE_TOP);
    active   = (state_q == RUN_B) ? black_time_q : white_time_q;
    active_d = active;
    bump     = 32'(active) + 32'(INC_SEC) - (tick ? 32'd1 : 32'd0);
    inc_val  = (bump > MAX_T) ? TIME_W'(MAX_T) : bump[TIME_W-1:0];

    case (state_q)
      IDLE, OVER: begin
        if (bus.start) begin
          state_d      = RUN_W;
          pre_d        = '0;
          white_time_d = START_T;
          black_time_d = START_T;
          white_win_d  = 1'b0;
          black_win_d  = 1'b0;
          turn_d       = 1'b0;
          running_d    = 1'b1;
        end
      end
      RUN_W, RUN_B: begin
        pre_d = tick ? '0 : pre_q + PRE_W'(1);
        if (bus.black_king_lost) begin
          white_win_d = 1'b1;
          state_d     = OVER;
          running_d   = 1'b0;
        end else if (bus.white_king_lost) begin
          black_win_d = 1'b1;
          state_d     = OVER;
          running_d   = 1'b0;
        end else if (tick && (active == TIME_W'(1))) begin
          // Flag falls: a move landing on the same tick is too late.
          active_d  = '0;
          state_d   = OVER;
          running_d = 1'b0;
          if (state_q == RUN_W) black_win_d = 1'b1;
          else                  white_win_d = 1'b1;
        end else if (bus.move_done) begin
          active_d = inc_val;
          pre_d    = '0;
          state_d  = (state_q == RUN_W) ? RUN_B : RUN_W;
          turn_d   = ~turn_q;
        end else if (tick) begin
          active_d = active - TIME_W'(1);
        end
        if (state_q == RUN_W) white_time_d = active_d;
        else                  black_time_d = active_d;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.white_win  = white_win_q;
  assign bus.black_win  = black_win_q;
  assign bus.white_time = white_time_q;
  assign bus.black_time = black_time_q;
  assign bus.turn       = turn_q;
  assign bus.running    = running_q;
endmodule

// File: tb/tb_chess_clock.sv
// Directed bench for chess_clock: a main instance (3 s, +1 s, 4-cycle second) and
// a saturation instance (15 s in a 4-bit counter); expectations flow through a queue.
module tb_chess_clock;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  typedef struct {
    string      tag;
    bit         sel;
    logic       ww, bw, turn, run;
    logic [3:0] wt, bt;
  } exp_t;

  exp_t sb[$];

  chess_clock_if #(.TIME_W(4)) bm ();
  chess_clock_if #(.TIME_W(4)) bs ();

  chess_clock #(.CYCLES_PER_SEC(4), .TIME_SEC(3), .INC_SEC(1), .TIME_W(4)) dut_main (
    .clk(clk), .rst(rst), .bus(bm)
  );

  chess_clock #(.CYCLES_PER_SEC(4), .TIME_SEC(15), .INC_SEC(1), .TIME_W(4)) dut_sat (
    .clk(clk), .rst(rst), .bus(bs)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input string field, input logic [3:0] obs, input logic [3:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("[TB] FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, exp_v);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    e = sb.pop_front();
    if (e.sel) begin
      cmp(e.tag, "white_win",  {3'b0, bs.white_win},  {3'b0, e.ww});
      cmp(e.tag, "black_win",  {3'b0, bs.black_win},  {3'b0, e.bw});
      cmp(e.tag, "turn",       {3'b0, bs.turn},       {3'b0, e.turn});
      cmp(e.tag, "running",    {3'b0, bs.running},    {3'b0, e.run});
      cmp(e.tag, "white_time", bs.white_time, e.wt);
      cmp(e.tag, "black_time", bs.black_time, e.bt);
    end else begin
      cmp(e.tag, "white_win",  {3'b0, bm.white_win},  {3'b0, e.ww});
      cmp(e.tag, "black_win",  {3'b0, bm.black_win},  {3'b0, e.bw});
      cmp(e.tag, "turn",       {3'b0, bm.turn},       {3'b0, e.turn});
      cmp(e.tag, "running",    {3'b0, bm.running},    {3'b0, e.run});
      cmp(e.tag, "white_time", bm.white_time, e.wt);
      cmp(e.tag, "black_time", bm.black_time, e.bt);
    end
  endtask

  // One clock: drive inputs, queue the expected outputs, sample #1 after the edge.
  task automatic applyStimulus(input string tag, input bit sel, input logic r,
                               input logic s, input logic m, input logic wk, input logic bk,
                               input logic ew, input logic eb, input logic et, input logic er,
                               input int ewt, input int ebt);
    exp_t e;
    rst = r;
    bm.start = 1'b0; bm.move_done = 1'b0; bm.white_king_lost = 1'b0; bm.black_king_lost = 1'b0;
    bs.start = 1'b0; bs.move_done = 1'b0; bs.white_king_lost = 1'b0; bs.black_king_lost = 1'b0;
    if (sel) begin
      bs.start = s; bs.move_done = m; bs.white_king_lost = wk; bs.black_king_lost = bk;
    end else begin
      bm.start = s; bm.move_done = m; bm.white_king_lost = wk; bm.black_king_lost = bk;
    end
    e.tag = tag; e.sel = sel; e.ww = ew; e.bw = eb; e.turn = et; e.run = er;
    e.wt = 4'(ewt); e.bt = 4'(ebt);
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
    rst = 1'b0;
    bm.start = 1'b0; bm.move_done = 1'b0; bm.white_king_lost = 1'b0; bm.black_king_lost = 1'b0;
    bs.start = 1'b0; bs.move_done = 1'b0; bs.white_king_lost = 1'b0; bs.black_king_lost = 1'b0;
  endtask

  task automatic idle(input string tag, input bit sel, input int n,
                      input logic ew, input logic eb, input logic et, input logic er,
                      input int ewt, input int ebt);
    for (int i = 0; i < n; i++)
      applyStimulus(tag, sel, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ew, eb, et, er, ewt, ebt);
  endtask

  initial begin
    bm.start = 1'b0; bm.move_done = 1'b0; bm.white_king_lost = 1'b0; bm.black_king_lost = 1'b0;
    bs.start = 1'b0; bs.move_done = 1'b0; bs.white_king_lost = 1'b0; bs.black_king_lost = 1'b0;

    applyStimulus("reset_main", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 3);
    applyStimulus("reset_sat",  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 15, 15);
    idle("idle_hold", 0, 2, 0, 0, 0, 0, 3, 3);

    // White runs out of time with no moves.
    applyStimulus("start", 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 3, 3);
    idle("w_count3", 0, 3, 0, 0, 0, 1, 3, 3);
    applyStimulus("w_tick2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3);
    idle("w_count2", 0, 3, 0, 0, 0, 1, 2, 3);
    applyStimulus("w_tick1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3);
    idle("w_count1", 0, 3, 0, 0, 0, 1, 1, 3);
    applyStimulus("w_timeout", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3);
    idle("over_hold", 0, 20, 0, 1, 0, 0, 0, 3);
    applyStimulus("over_ignores", 0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 3);

    // Restart from OVER, then moves with increment.
    applyStimulus("restart", 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 3, 3);
    idle("pre_to_1", 0, 1, 0, 0, 0, 1, 3, 3);
    applyStimulus("move_noTick", 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 4, 3);
    idle("b_count", 0, 3, 0, 0, 1, 1, 4, 3);
    applyStimulus("b_tick", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4, 2);
    applyStimulus("start_in_runB", 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 4, 2);
    applyStimulus("b_move", 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 4, 3);
    idle("w_count", 0, 3, 0, 0, 0, 1, 4, 3);
    applyStimulus("move_onTick", 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 4, 3);
    idle("b_run", 0, 1, 0, 0, 1, 1, 4, 3);
    applyStimulus("rst_midB", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 3);

    // King capture on the same tick that would have timed white out.
    applyStimulus("k_start", 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 3, 3);
    idle("k_c3", 0, 3, 0, 0, 0, 1, 3, 3);
    applyStimulus("k_t2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3);
    idle("k_c2", 0, 3, 0, 0, 0, 1, 2, 3);
    applyStimulus("k_t1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3);
    idle("k_c1", 0, 3, 0, 0, 0, 1, 1, 3);
    applyStimulus("king_beats_tick", 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 3);
    idle("king_hold", 0, 3, 1, 0, 0, 0, 1, 3);

    // Increment saturates at the counter maximum; then white's king falls.
    applyStimulus("sat_start", 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 15, 15);
    applyStimulus("sat_move", 1, 0, 0, 1, 0, 0, 0, 0, 1, 1, 15, 15);
    applyStimulus("sat_wking", 1, 0, 0, 0, 1, 0, 0, 1, 1, 0, 15, 15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
